s_p_frame_ctrl: RTL and testbench

- Frame sequencer for the serial-to-parallel converter: gates the per-bit shift, counts bits, and issues the one-cycle latch-enable strobe (CAPTURE) once a full word has been shifted in.
- Presents the captured word to downstream logic with a valid/ready handshake and flags overruns.
- Sits between the serial link front end and the converter; replaces free-running ring-counter sequencing with START/ABORT-controlled framing.

---
 rtl/s_p_frame_ctrl_if.sv | 29 ++
 rtl/s_p_frame_ctrl.sv | 132 +++++++++++++
 tb/tb_s_p_frame_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/s_p_frame_ctrl_if.sv
// Control/status bundle between the serial front end, the converter and downstream logic.
// The master side drives framing and handshake inputs; the slave side is the frame sequencer.
interface s_p_frame_ctrl_if #(
  parameter int C_BITS_OUT = 255
);
  localparam int CW = $clog2(C_BITS_OUT);

  logic          start;
  logic          ser_valid;
  logic          abort;
  logic          out_ready;
  logic          clr_ovr;
  logic          shift_en;
  logic          capture;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          out_valid;
  logic          overrun;

  modport master (
    output start, ser_valid, abort, out_ready, clr_ovr,
    input  shift_en, capture, bit_cnt, busy, out_valid, overrun
  );

  modport slave (
    input  start, ser_valid, abort, out_ready, clr_ovr,
    output shift_en, capture, bit_cnt, busy, out_valid, overrun
  );
endinterface

// File: rtl/s_p_frame_ctrl.sv
// Frame sequencer for the serial-to-parallel converter: shift gating, bit counting, capture strobe,
// output valid/ready handshake and sticky overrun. Define SPC_FRAME_CTRL_AUTO_RESTART_EN to stream frames back to back.
module s_p_frame_ctrl #(
  parameter int C_BITS_OUT = 255,
  localparam int CW        = $clog2(C_BITS_OUT)
) (
  input  logic              i_ck,
  input  logic              i_rst,
  s_p_frame_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_LAST_BIT = CW'(C_BITS_OUT - 1);
  localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] C_CNT_ZERO = CW'(0);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_bit_cnt_nxt;
  logic          r_out_valid;
  logic          w_out_valid_nxt;
  logic          r_overrun;
  logic          w_overrun_nxt;
  logic          w_shift_en;
  logic          w_capture;
  logic          w_cap_suppress;

  // Next-state, bit counter and strobe decode
  always_comb begin
    w_next_state   = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_en     = 1'b0;
    w_capture      = 1'b0;
    w_cap_suppress = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_next_state  = ST_SHIFT;
          w_bit_cnt_nxt = C_CNT_ZERO;
        end else begin
          w_next_state  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (bus.abort) begin
          w_next_state  = ST_IDLE;
          w_bit_cnt_nxt = C_CNT_ZERO;
        end else if (bus.start) begin
          // resync: restart the count without shifting this cycle
          w_bit_cnt_nxt = C_CNT_ZERO;
        end else if (bus.ser_valid) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == C_LAST_BIT) begin
            w_next_state  = ST_CAP;
            w_bit_cnt_nxt = C_CNT_ZERO;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + C_CNT_ONE;
          end
        end else begin
          w_bit_cnt_nxt = r_bit_cnt;
        end
      end
      ST_CAP: begin
        // an unread word that is not being accepted now must not be overwritten
        if (r_out_valid && !bus.out_ready) begin
          w_cap_suppress = 1'b1;
        end else begin
          w_capture = 1'b1;
        end
        w_bit_cnt_nxt = C_CNT_ZERO;
`ifdef SPC_FRAME_CTRL_AUTO_RESTART_EN
        w_next_state  = ST_SHIFT;
`else
        w_next_state  = ST_IDLE;
`endif
      end
      default: begin
        w_next_state  = ST_IDLE;
        w_bit_cnt_nxt = C_CNT_ZERO;
      end
    endcase
  end

  // Output handshake and sticky overrun update
  always_comb begin
    w_out_valid_nxt = r_out_valid;
    w_overrun_nxt   = r_overrun;
    if (w_capture) begin
      w_out_valid_nxt = 1'b1;
    end else if (r_out_valid && bus.out_ready) begin
      w_out_valid_nxt = 1'b0;
    end else begin
      w_out_valid_nxt = r_out_valid;
    end
    if (w_cap_suppress) begin
      w_overrun_nxt = 1'b1;
    end else if (bus.clr_ovr) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  // State and status registers
  always_ff @(posedge i_ck or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= C_CNT_ZERO;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign bus.shift_en  = w_shift_en;
  assign bus.capture   = w_capture;
  assign bus.bit_cnt   = r_bit_cnt;
  assign bus.busy      = (r_state == ST_SHIFT) || (r_state == ST_CAP);
  assign bus.out_valid = r_out_valid;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_s_p_frame_ctrl.sv
// Directed self-checking bench for s_p_frame_ctrl with C_BITS_OUT=8.
// Build with SPC_FRAME_CTRL_AUTO_RESTART_EN defined to exercise back-to-back streaming.
module tb_s_p_frame_ctrl;
  localparam int NB = 8;

  logic ck  = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   sh_cnt;
  int   cap_cnt;

  s_p_frame_ctrl_if #(.C_BITS_OUT(NB)) bus ();

  s_p_frame_ctrl #(.C_BITS_OUT(NB)) dut (
    .i_ck  (ck),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic idle_in();
    bus.start     = 1'b0;
    bus.ser_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.clr_ovr   = 1'b0;
  endtask

  task automatic start_frame();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // n cycles of valid serial input, tallying strobes seen before each edge
  task automatic shift_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.ser_valid = 1'b1;
      #1;
      if (bus.shift_en) sh_cnt++;
      if (bus.capture)  cap_cnt++;
      tick();
    end
    bus.ser_valid = 1'b0;
  endtask

  initial begin
    int caps[$];
    idle_in();
    bus.out_ready = 1'b0;
    #1;
    check("rst_bit_cnt",   32'(bus.bit_cnt),   32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overrun",   32'(bus.overrun),   32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_shift_en",  32'(bus.shift_en),  32'd0);
    check("rst_capture",   32'(bus.capture),   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // reset mid-frame
    start_frame();
    shift_bits(3);
    check("mid_cnt3", 32'(bus.bit_cnt), 32'd3);
    bus.ser_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_busy",     32'(bus.busy),     32'd0);
    check("arst_bit_cnt",  32'(bus.bit_cnt),  32'd0);
    check("arst_shift_en", 32'(bus.shift_en), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("arst_needs_start", 32'(bus.busy), 32'd0);
    bus.ser_valid = 1'b0;

`ifdef SPC_FRAME_CTRL_AUTO_RESTART_EN
    // streaming: one START, continuous valid input
    bus.out_ready = 1'b1;
    start_frame();
    for (int c = 0; c < 27; c++) begin
      bus.ser_valid = 1'b1;
      #1;
      if (bus.capture) caps.push_back(c);
      tick();
    end
    check("auto_cap_count", 32'(caps.size()), 32'd3);
    if (caps.size() == 3) begin
      check("auto_first_cap", 32'(caps[0]), 32'd8);
      check("auto_gap1", 32'(caps[1] - caps[0]), 32'd9);
      check("auto_gap2", 32'(caps[2] - caps[1]), 32'd9);
    end
    check("auto_no_ovr", 32'(bus.overrun), 32'd0);
    check("auto_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.ser_valid = 1'b0;
    check("auto_abort_idle", 32'(bus.busy), 32'd0);
`else
    // basic frame
    bus.out_ready = 1'b1;
    sh_cnt = 0; cap_cnt = 0;
    start_frame();
    check("basic_busy", 32'(bus.busy), 32'd1);
    shift_bits(NB);
    check("basic_shift_pulses", 32'(sh_cnt), 32'd8);
    check("basic_no_early_cap", 32'(cap_cnt), 32'd0);
    bus.ser_valid = 1'b1;
    #1;
    check("basic_capture", 32'(bus.capture), 32'd1);
    check("basic_cap_noshift", 32'(bus.shift_en), 32'd0);
    check("basic_cap_cnt0", 32'(bus.bit_cnt), 32'd0);
    tick();
    check("basic_out_valid", 32'(bus.out_valid), 32'd1);
    check("basic_cap_1cyc", 32'(bus.capture), 32'd0);
    check("basic_to_idle", 32'(bus.busy), 32'd0);
    bus.ser_valid = 1'b0;
    tick();
    check("basic_ov_cleared", 32'(bus.out_valid), 32'd0);

    // gapped input: 8 valid bits, 3 idle cycles
    sh_cnt = 0; cap_cnt = 0;
    start_frame();
    for (int i = 0; i < 11; i++) begin
      bus.ser_valid = (i % 3 == 2) ? 1'b0 : 1'b1;
      #1;
      if (bus.shift_en) sh_cnt++;
      if (bus.capture)  cap_cnt++;
      tick();
    end
    bus.ser_valid = 1'b0;
    check("gap_shift_pulses", 32'(sh_cnt), 32'd8);
    check("gap_no_early_cap", 32'(cap_cnt), 32'd0);
    #1;
    check("gap_capture", 32'(bus.capture), 32'd1);
    tick();
    check("gap_out_valid", 32'(bus.out_valid), 32'd1);
    tick();

    // abort after 5 bits
    cap_cnt = 0;
    start_frame();
    shift_bits(5);
    bus.abort = 1'b1;
    bus.ser_valid = 1'b1;
    #1;
    check("abort_noshift", 32'(bus.shift_en), 32'd0);
    tick();
    bus.abort = 1'b0;
    check("abort_idle", 32'(bus.busy), 32'd0);
    check("abort_cnt0", 32'(bus.bit_cnt), 32'd0);
    shift_bits(4);
    check("abort_no_cap", 32'(cap_cnt), 32'd0);

    // resync after 4 bits
    start_frame();
    shift_bits(4);
    check("resync_cnt4", 32'(bus.bit_cnt), 32'd4);
    bus.start = 1'b1;
    bus.ser_valid = 1'b1;
    #1;
    check("resync_noshift", 32'(bus.shift_en), 32'd0);
    tick();
    bus.start = 1'b0;
    check("resync_cnt0", 32'(bus.bit_cnt), 32'd0);
    check("resync_busy", 32'(bus.busy), 32'd1);
    cap_cnt = 0;
    shift_bits(7);
    check("resync_cnt7", 32'(bus.bit_cnt), 32'd7);
    check("resync_no_early_cap", 32'(cap_cnt), 32'd0);
    shift_bits(1);
    #1;
    check("resync_capture", 32'(bus.capture), 32'd1);
    tick();
    tick();
    check("resync_ov_cleared", 32'(bus.out_valid), 32'd0);

    // overrun
    bus.out_ready = 1'b0;
    start_frame();
    shift_bits(NB);
    #1;
    check("ovr_first_cap", 32'(bus.capture), 32'd1);
    tick();
    check("ovr_first_valid", 32'(bus.out_valid), 32'd1);
    check("ovr_first_noovr", 32'(bus.overrun), 32'd0);
    start_frame();
    shift_bits(NB);
    #1;
    check("ovr_second_suppr", 32'(bus.capture), 32'd0);
    tick();
    check("ovr_set", 32'(bus.overrun), 32'd1);
    check("ovr_valid_kept", 32'(bus.out_valid), 32'd1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("ovr_cleared", 32'(bus.overrun), 32'd0);
    // set beats simultaneous clear
    start_frame();
    shift_bits(NB);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    check("ovr_set_wins", 32'(bus.overrun), 32'd1);
    bus.clr_ovr = 1'b1;
    tick();
    bus.clr_ovr = 1'b0;
    // accept coinciding with CAP
    start_frame();
    shift_bits(NB);
    bus.out_ready = 1'b1;
    #1;
    check("acc_cap", 32'(bus.capture), 32'd1);
    tick();
    check("acc_valid_new", 32'(bus.out_valid), 32'd1);
    check("acc_no_ovr", 32'(bus.overrun), 32'd0);
    tick();
    check("acc_drained", 32'(bus.out_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
